// File: rtl/jimmy_pkg.sv
// Shared definitions for the jimmy core front end.
// Contents:
//   - opcode byte constants (ADD ... NOP)
//   - register codes R0..R3
//   - fetch_state_t: fetch sequencer states
//   - is_two_byte(): instruction length rule keyed on byte0
// Optional feature macro used by the fetch unit: SELF_LOOP_HALT_EN
package jimmy_pkg;

  // Opcode byte values (register fields zero). The length rule below
  // is what classifies them; these are the canonical encodings.
  localparam logic [7:0] OP_ADD     = 8'h00;
  localparam logic [7:0] OP_MUL     = 8'h10;
  localparam logic [7:0] OP_MOV     = 8'h20;
  localparam logic [7:0] OP_LD_IMM  = 8'h80;
  localparam logic [7:0] OP_CMP_IMM = 8'h8C;
  localparam logic [7:0] OP_DEC     = 8'h90;
  localparam logic [7:0] OP_INPUT   = 8'h98;
  localparam logic [7:0] OP_OUTPUT  = 8'h9C;
  localparam logic [7:0] OP_BRA     = 8'hA8;
  localparam logic [7:0] OP_BHI     = 8'hB0;
  localparam logic [7:0] OP_BEQ     = 8'hB8;
  localparam logic [7:0] OP_NOP     = 8'hF0;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;

  typedef enum logic [1:0] {
    FETCH1 = 2'd0,
    FETCH2 = 2'd1,
    ISSUE  = 2'd2,
    HALT   = 2'd3
  } fetch_state_t;

  // LD_IMM, CMP_IMM and the three branches carry an immediate byte.
  function automatic logic is_two_byte(input logic [7:0] byte0);
    logic result;
    result = (byte0[7:2] == 6'b100000) ||
             (byte0[7:2] == 6'b100011) ||
             (byte0[7:5] == 3'b101);
    return result;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_length_decode.sv
// instr_length_decode: combinational byte0 -> instruction length.
// Shared between the fetch unit and the disassembler/monitor so both
// agree on the length rule.
// Ports:
//   i_byte0      in  8  first instruction byte
//   o_instr_len  out 1  0 = 1-byte, 1 = 2-byte
module instr_length_decode
  import jimmy_pkg::*;
(
  input  logic [7:0] i_byte0,
  output logic       o_instr_len
);

  assign o_instr_len = is_two_byte(i_byte0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: walks the PC over the 8-bit program ROM,
// assembles 1- or 2-byte instructions into a 16-bit word and hands it
// to the decoder over valid/ready. Branch redirects restart fetch.
// Optional feature: define SELF_LOOP_HALT_EN to stop fetching when a
// BRA-to-itself is accepted (halted goes high, sticky until reset).
// Ports:
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous active-low reset
//   address_bus    out  8   ROM address (= pc)
//   data_bus       in   8   ROM read data (combinational)
//   instr          out  16  {byte0, byte1}, byte1 = 0 for 1-byte
//   instr_len      out  1   0 = 1-byte, 1 = 2-byte
//   instr_pc       out  8   address of byte0
//   instr_valid    out  1   instruction outputs valid
//   instr_ready    in   1   decoder accepts
//   branch_taken   in   1   redirect request
//   branch_target  in   8   redirect address
//   halted         out  1   self-loop halt (0 without the macro)
module instruction_fetch_unit
  import jimmy_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  address_bus,
  input  logic [7:0]  data_bus,
  output logic [15:0] instr,
  output logic        instr_len,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic        halted
);

  localparam logic [1:0] ST_FETCH1 = FETCH1;
  localparam logic [1:0] ST_FETCH2 = FETCH2;
  localparam logic [1:0] ST_ISSUE  = ISSUE;
  localparam logic [1:0] ST_HALT   = HALT;

  logic [1:0] r_state;
  logic [7:0] r_pc;
  logic [7:0] r_ir_hi;
  logic [7:0] r_ir_lo;
  logic [7:0] r_instr_pc;
  logic       r_len;
  logic       r_valid;
  logic       w_len;
  logic       w_halted;
  logic       w_redirect;

  instr_length_decode u_len_dec (
    .i_byte0     (data_bus),
    .o_instr_len (w_len)
  );

`ifdef SELF_LOOP_HALT_EN
  logic r_halted;
  logic w_self_loop;

  // Accepted BRA whose target is its own address can never make progress.
  assign w_self_loop = (r_ir_hi == OP_BRA) && (r_ir_lo == r_instr_pc);
  assign w_halted    = r_halted;

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_halted <= 1'b0;
    end else if (!w_redirect && (r_state == ST_ISSUE) && instr_ready && w_self_loop) begin
      r_halted <= 1'b1;
    end else begin
      r_halted <= r_halted;
    end
  end
`else
  assign w_halted = 1'b0;
`endif

  // Redirects are ignored once halted; otherwise they beat every FSM move.
  assign w_redirect = branch_taken && !w_halted;

  // Fetch sequencer: PC walk, instruction assembly and issue handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_FETCH1;
      r_pc       <= RESET_PC;
      r_ir_hi    <= 8'h00;
      r_ir_lo    <= 8'h00;
      r_instr_pc <= 8'h00;
      r_len      <= 1'b0;
      r_valid    <= 1'b0;
    end else if (w_redirect) begin
      // Any partial or un-accepted instruction is dropped here.
      r_pc    <= branch_target;
      r_state <= ST_FETCH1;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH1: begin
          r_ir_hi    <= data_bus;
          r_ir_lo    <= 8'h00;
          r_instr_pc <= r_pc;
          r_len      <= w_len;
          r_pc       <= r_pc + 8'd1;
          if (w_len) begin
            r_state <= ST_FETCH2;
            r_valid <= 1'b0;
          end else begin
            r_state <= ST_ISSUE;
            r_valid <= 1'b1;
          end
        end
        ST_FETCH2: begin
          r_ir_lo <= data_bus;
          r_pc    <= r_pc + 8'd1;
          r_state <= ST_ISSUE;
          r_valid <= 1'b1;
        end
        ST_ISSUE: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
`ifdef SELF_LOOP_HALT_EN
            if (w_self_loop) begin
              r_state <= ST_HALT;
            end else begin
              r_state <= ST_FETCH1;
            end
`else
            r_state <= ST_FETCH1;
`endif
          end else begin
            r_state <= ST_ISSUE;
            r_valid <= 1'b1;
          end
        end
        ST_HALT: begin
          r_valid <= 1'b0;
`ifdef SELF_LOOP_HALT_EN
          r_state <= ST_HALT;
`else
          r_state <= ST_FETCH1;
`endif
        end
        default: begin
          r_state <= ST_FETCH1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign address_bus = r_pc;
  assign instr       = {r_ir_hi, r_ir_lo};
  assign instr_len   = r_len;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign halted      = w_halted;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  address_bus;
  logic [7:0]  data_bus;
  logic [15:0] instr;
  logic        instr_len;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        halted;

  logic [7:0] rom [256];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign data_bus = rom[address_bus];

  instruction_fetch_unit #(.RESET_PC(8'h00)) dut (
    .clk           (clk),
    .reset         (reset),
    .address_bus   (address_bus),
    .data_bus      (data_bus),
    .instr         (instr),
    .instr_len     (instr_len),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halted        (halted)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        exp_len;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    branch_taken = 1'b0;
    instr_ready = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    #12;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Length rule applied straight from the instruction-set definition.
  function automatic int two_byte(input logic [7:0] b);
    if (b[7:2] == 6'd32 || b[7:2] == 6'd35 || b[7:5] == 3'd5) return 1;
    return 0;
  endfunction

  // Transaction-level model: where the current instruction starts and how
  // many cycles have been spent on it since fetch began.
  logic [7:0] m_ptr;
  int         m_cnt;

  function automatic int m_need();
    return 1 + two_byte(rom[m_ptr]);
  endfunction

  initial begin
    int n;
    logic [7:0] p1;
    logic [15:0] e_instr;

    vecs[0] = '{8'h82, 8'h00, 1'b1, 16'h8200};
    vecs[1] = '{8'h98, 8'h55, 1'b0, 16'h9800};
    vecs[2] = '{8'h8C, 8'h12, 1'b1, 16'h8C12};
    vecs[3] = '{8'hA8, 8'h07, 1'b1, 16'hA807};
    vecs[4] = '{8'hB4, 8'hFF, 1'b1, 16'hB4FF};
    vecs[5] = '{8'h7F, 8'h33, 1'b0, 16'h7F00};
    vecs[6] = '{8'h84, 8'h01, 1'b0, 16'h8400};
    vecs[7] = '{8'hE0, 8'h11, 1'b0, 16'hE000};

    // Reset values.
    hold_reset();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_pc", {24'd0, instr_pc}, 32'd0);
    chk("rst_addr", {24'd0, address_bus}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // Table: single instruction at address 0, latency and assembly.
    for (int v = 0; v < 8; v++) begin
      hold_reset();
      rom[0] = vecs[v].b0;
      rom[1] = vecs[v].b1;
      release_reset();
      n = 0;
      while (!instr_valid && n < 10) begin
        tick();
        n++;
      end
      chk("tbl_latency", n, vecs[v].exp_len ? 32'd2 : 32'd1);
      chk("tbl_instr", {16'd0, instr}, {16'd0, vecs[v].exp_instr});
      chk("tbl_len", {31'd0, instr_len}, {31'd0, vecs[v].exp_len});
      chk("tbl_ipc", {24'd0, instr_pc}, 32'd0);
      chk("tbl_addr", {24'd0, address_bus}, vecs[v].exp_len ? 32'd2 : 32'd1);
    end

    // Sequences 1-4: LD_IMM, INPUT with stall, redirect during FETCH2.
    hold_reset();
    rom[0] = 8'h82; rom[1] = 8'h00; rom[2] = 8'h98;
    rom[3] = 8'h8C; rom[4] = 8'h9C; rom[5] = 8'h00;
    instr_ready = 1'b1;
    release_reset();
    tick();
    chk("s1_nvalid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("s1_valid", {31'd0, instr_valid}, 32'd1);
    chk("s1_instr", {16'd0, instr}, 32'h8200);
    chk("s1_len", {31'd0, instr_len}, 32'd1);
    tick();
    instr_ready = 1'b0;
    tick();
    chk("s2_valid", {31'd0, instr_valid}, 32'd1);
    chk("s2_instr", {16'd0, instr}, 32'h9800);
    chk("s2_len", {31'd0, instr_len}, 32'd0);
    chk("s2_ipc", {24'd0, instr_pc}, 32'd2);
    chk("s2_addr", {24'd0, address_bus}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s3_hold_instr", {16'd0, instr}, 32'h9800);
      chk("s3_hold_addr", {24'd0, address_bus}, 32'd3);
      chk("s3_hold_valid", {31'd0, instr_valid}, 32'd1);
    end
    instr_ready = 1'b1;
    tick();
    chk("s3_accept_valid", {31'd0, instr_valid}, 32'd0);
    chk("s3_next_addr", {24'd0, address_bus}, 32'd3);
    tick();
    chk("s4_in_fetch2", {24'd0, address_bus}, 32'd4);
    branch_taken = 1'b1;
    branch_target = 8'h04;
    tick();
    branch_taken = 1'b0;
    chk("s4_discard_valid", {31'd0, instr_valid}, 32'd0);
    chk("s4_addr", {24'd0, address_bus}, 32'd4);
    tick();
    chk("s4_new_instr", {16'd0, instr}, 32'h9C00);
    chk("s4_new_ipc", {24'd0, instr_pc}, 32'd4);

    // Sequence 5: 2-byte instruction wrapping past 8'hFF.
    hold_reset();
    rom[8'hFF] = 8'hB4; rom[0] = 8'h0C;
    release_reset();
    branch_taken = 1'b1;
    branch_target = 8'hFF;
    tick();
    branch_taken = 1'b0;
    tick();
    chk("s5_wrap_addr", {24'd0, address_bus}, 32'd0);
    tick();
    chk("s5_instr", {16'd0, instr}, 32'hB40C);
    chk("s5_ipc", {24'd0, instr_pc}, 32'hFF);
    chk("s5_addr", {24'd0, address_bus}, 32'd1);

    // Sequence 6: self-branch.
    hold_reset();
    rom[13] = 8'hA8; rom[14] = 8'h0D;
    release_reset();
    instr_ready = 1'b1;
    branch_taken = 1'b1;
    branch_target = 8'h0D;
    tick();
    branch_taken = 1'b0;
    tick();
    tick();
    chk("s6_instr", {16'd0, instr}, 32'hA80D);
    chk("s6_addr", {24'd0, address_bus}, 32'h0F);
    tick();
    branch_taken = 1'b1;
    branch_target = 8'h0D;
`ifdef SELF_LOOP_HALT_EN
    chk("s6_halted", {31'd0, halted}, 32'd1);
    chk("s6_valid", {31'd0, instr_valid}, 32'd0);
    branch_target = 8'h20;
    tick();
    tick();
    branch_taken = 1'b0;
    chk("s6_frozen", {24'd0, address_bus}, 32'h0F);
    chk("s6_sticky", {31'd0, halted}, 32'd1);
`else
    chk("s6_halted", {31'd0, halted}, 32'd0);
    tick();
    branch_taken = 1'b0;
    chk("s6_refetch", {24'd0, address_bus}, 32'h0D);
    tick();
    tick();
    chk("s6_again", {16'd0, instr}, 32'hA80D);
`endif

    // Sequence 7: asynchronous reset in the middle of FETCH2.
    hold_reset();
    rom[0] = 8'h98; rom[1] = 8'h82; rom[2] = 8'h11;
    release_reset();
    instr_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("s7_pre_addr", {24'd0, address_bus}, 32'd2);
    reset = 1'b0;
    #1;
    chk("s7_instr", {16'd0, instr}, 32'd0);
    chk("s7_ipc", {24'd0, instr_pc}, 32'd0);
    chk("s7_addr", {24'd0, address_bus}, 32'd0);
    chk("s7_valid", {31'd0, instr_valid}, 32'd0);
    release_reset();
    tick();
    chk("s7_refetch", {16'd0, instr}, 32'h9800);

    // Random phase against the transaction model.
    hold_reset();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($urandom_range(0, 255));
      if (rom[i] == 8'hA8) rom[i] = 8'hAC;
    end
    release_reset();
    m_ptr = 8'h00;
    m_cnt = 0;
    chk("rnd_start_addr", {24'd0, address_bus}, 32'd0);
    for (int c = 0; c < 600; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 11) == 0);
      branch_target = 8'($urandom_range(0, 255));
      if (branch_taken) begin
        m_ptr = branch_target;
        m_cnt = 0;
      end else if (m_cnt == m_need() && instr_ready) begin
        m_ptr = m_ptr + 8'(m_need());
        m_cnt = 0;
      end else if (m_cnt < m_need()) begin
        m_cnt++;
      end
      tick();
      chk("rnd_valid", {31'd0, instr_valid}, (m_cnt == m_need()) ? 32'd1 : 32'd0);
      chk("rnd_addr", {24'd0, address_bus}, {24'd0, m_ptr + 8'(m_cnt)});
      if (m_cnt == m_need()) begin
        p1 = m_ptr + 8'd1;
        e_instr = {rom[m_ptr], (m_need() == 2) ? rom[p1] : 8'h00};
        chk("rnd_instr", {16'd0, instr}, {16'd0, e_instr});
        chk("rnd_ipc", {24'd0, instr_pc}, {24'd0, m_ptr});
        chk("rnd_len", {31'd0, instr_len}, m_need() - 1);
      end
      chk("rnd_halted", {31'd0, halted}, 32'd0);
    end
    branch_taken = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
